// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing constants and hazard bit positions for the register scoreboard.
package reg_scoreboard_pkg;
    localparam int NREG   = 32;
    localparam int ID_W   = 5;
    localparam int CNT_W  = 6;

    localparam int HZ_RS1 = 0;
    localparam int HZ_RS2 = 1;
    localparam int HZ_RD  = 2;
    localparam int HZ_W   = 3;
endpackage

// File: rtl/sb_hazard_check.sv
// Combinational hazard lookup: registered busy vector plus operand ids to stall bits.
module sb_hazard_check
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG = reg_scoreboard_pkg::NREG,
    parameter int ID_W = reg_scoreboard_pkg::ID_W
) (
    input  logic [NREG-1:0] busy_vec,
    input  logic            rs1_en,
    input  logic [ID_W-1:0] rs1_id,
    input  logic            rs2_en,
    input  logic [ID_W-1:0] rs2_id,
    input  logic            rd_en,
    input  logic [ID_W-1:0] rd_id,
    output logic [HZ_W-1:0] hazard
);
    // x0 is excluded explicitly so a stray busy bit 0 could never stall issue.
    always_comb begin
        hazard         = '0;
        hazard[HZ_RS1] = rs1_en && (rs1_id != '0) && busy_vec[rs1_id];
        hazard[HZ_RS2] = rs2_en && (rs2_id != '0) && busy_vec[rs2_id];
        hazard[HZ_RD]  = rd_en  && (rd_id  != '0) && busy_vec[rd_id];
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue gate: tracks in-flight writes and blocks RAW/WAW hazards.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int ID_W  = reg_scoreboard_pkg::ID_W,
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic             issue_rs1_en_i,
    input  logic [ID_W-1:0]  issue_rs1_id_i,
    input  logic             issue_rs2_en_i,
    input  logic [ID_W-1:0]  issue_rs2_id_i,
    input  logic             issue_rd_en_i,
    input  logic [ID_W-1:0]  issue_rd_id_i,
    input  logic             cmpl0_valid_i,
    input  logic [ID_W-1:0]  cmpl0_rd_id_i,
    input  logic             cmpl1_valid_i,
    input  logic [ID_W-1:0]  cmpl1_rd_id_i,
    input  logic             flush_i,
    output logic [NREG-1:0]  busy_vec_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             idle_o,
    output logic [HZ_W-1:0]  hazard_o,
    output logic             spurious_err_o
);
    logic [NREG-1:0]  busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic             fire;
    logic             set_en;
    logic             c0_hit;
    logic             c1_hit;
    logic             dup_clr;
    logic             spurious;
    logic [CNT_W-1:0] n_clr;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  clr_vec;
    logic [NREG-1:0]  busy_nxt;

    sb_hazard_check #(
        .NREG (NREG),
        .ID_W (ID_W)
    ) u_hazard (
        .busy_vec (busy_q),
        .rs1_en   (issue_rs1_en_i),
        .rs1_id   (issue_rs1_id_i),
        .rs2_en   (issue_rs2_en_i),
        .rs2_id   (issue_rs2_id_i),
        .rd_en    (issue_rd_en_i),
        .rd_id    (issue_rd_id_i),
        .hazard   (hazard_o)
    );

    assign issue_ready_o = !flush_i && !(|hazard_o);
    assign fire          = issue_valid_i && issue_ready_o;
    assign set_en        = fire && issue_rd_en_i && (issue_rd_id_i != '0);

    // Only completions that hit a busy bit count; both ports on one register decrement once.
    assign c0_hit   = cmpl0_valid_i && (cmpl0_rd_id_i != '0) && busy_q[cmpl0_rd_id_i];
    assign c1_hit   = cmpl1_valid_i && (cmpl1_rd_id_i != '0) && busy_q[cmpl1_rd_id_i];
    assign dup_clr  = c0_hit && c1_hit && (cmpl0_rd_id_i == cmpl1_rd_id_i);
    assign n_clr    = CNT_W'(c0_hit) + CNT_W'(c1_hit && !dup_clr);
    assign spurious = (cmpl0_valid_i && !busy_q[cmpl0_rd_id_i])
                   || (cmpl1_valid_i && !busy_q[cmpl1_rd_id_i]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[issue_rd_id_i] = 1'b1;
        if (c0_hit) clr_vec[cmpl0_rd_id_i] = 1'b1;
        if (c1_hit) clr_vec[cmpl1_rd_id_i] = 1'b1;
        busy_nxt    = (busy_q & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    // State update: flush wipes in-flight writes but leaves the sticky error alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (flush_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_q + CNT_W'(set_en) - n_clr;
            err_q  <= err_q | spurious;
        end
    end

    assign busy_vec_o     = busy_q;
    assign outstanding_o  = cnt_q;
    assign idle_o         = (cnt_q == '0);
    assign spurious_err_o = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic        issue_rs1_en_i;
    logic [4:0]  issue_rs1_id_i;
    logic        issue_rs2_en_i;
    logic [4:0]  issue_rs2_id_i;
    logic        issue_rd_en_i;
    logic [4:0]  issue_rd_id_i;
    logic        cmpl0_valid_i;
    logic [4:0]  cmpl0_rd_id_i;
    logic        cmpl1_valid_i;
    logic [4:0]  cmpl1_rd_id_i;
    logic        flush_i;
    logic [31:0] busy_vec_o;
    logic [5:0]  outstanding_o;
    logic        idle_o;
    logic [2:0]  hazard_o;
    logic        spurious_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_rs1_en_i (issue_rs1_en_i),
        .issue_rs1_id_i (issue_rs1_id_i),
        .issue_rs2_en_i (issue_rs2_en_i),
        .issue_rs2_id_i (issue_rs2_id_i),
        .issue_rd_en_i  (issue_rd_en_i),
        .issue_rd_id_i  (issue_rd_id_i),
        .cmpl0_valid_i  (cmpl0_valid_i),
        .cmpl0_rd_id_i  (cmpl0_rd_id_i),
        .cmpl1_valid_i  (cmpl1_valid_i),
        .cmpl1_rd_id_i  (cmpl1_rd_id_i),
        .flush_i        (flush_i),
        .busy_vec_o     (busy_vec_o),
        .outstanding_o  (outstanding_o),
        .idle_o         (idle_o),
        .hazard_o       (hazard_o),
        .spurious_err_o (spurious_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i  = 1'b0;
        issue_rs1_en_i = 1'b0;
        issue_rs1_id_i = '0;
        issue_rs2_en_i = 1'b0;
        issue_rs2_id_i = '0;
        issue_rd_en_i  = 1'b0;
        issue_rd_id_i  = '0;
        cmpl0_valid_i  = 1'b0;
        cmpl0_rd_id_i  = '0;
        cmpl1_valid_i  = 1'b0;
        cmpl1_rd_id_i  = '0;
        flush_i        = 1'b0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_id_i = rd;
        step();
        issue_valid_i = 1'b0;
        issue_rd_en_i = 1'b0;
        issue_rd_id_i = '0;
    endtask

    initial begin
        logic [31:0] exp_busy;
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_busy",   busy_vec_o,     32'h0);
        check("rst_out",    outstanding_o,  32'd0);
        check("rst_idle",   idle_o,         32'd1);
        check("rst_err",    spurious_err_o, 32'd0);
        check("rst_hazard", hazard_o,       32'd0);
        check("rst_ready",  issue_ready_o,  32'd1);

        // Issue rd=5 reading x0
        issue_valid_i  = 1'b1;
        issue_rs1_en_i = 1'b1;
        issue_rs1_id_i = 5'd0;
        issue_rd_en_i  = 1'b1;
        issue_rd_id_i  = 5'd5;
        #1;
        check("iss5_ready", issue_ready_o, 32'd1);
        step();
        idle_inputs();
        #1;
        check("iss5_busy", busy_vec_o,    32'h20);
        check("iss5_out",  outstanding_o, 32'd1);
        check("iss5_idle", idle_o,        32'd0);

        // RAW on rs2=5, released by cmpl1
        issue_valid_i  = 1'b1;
        issue_rs2_en_i = 1'b1;
        issue_rs2_id_i = 5'd5;
        #1;
        check("raw_ready",  issue_ready_o, 32'd0);
        check("raw_hazard", hazard_o,      32'h2);
        step();
        cmpl1_valid_i = 1'b1;
        cmpl1_rd_id_i = 5'd5;
        #1;
        check("raw_nobypass", issue_ready_o, 32'd0);
        step();
        cmpl1_valid_i = 1'b0;
        #1;
        check("raw_rel_ready", issue_ready_o, 32'd1);
        check("raw_rel_out",   outstanding_o, 32'd0);
        check("raw_rel_busy",  busy_vec_o,    32'h0);
        idle_inputs();

        // WAW plus dual completion on distinct registers
        issue_rd(5'd3);
        issue_rd(5'd7);
        #1;
        check("dual_busy", busy_vec_o,    32'h88);
        check("dual_out",  outstanding_o, 32'd2);
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_id_i = 5'd3;
        #1;
        check("waw_hazard", hazard_o,      32'h4);
        check("waw_ready",  issue_ready_o, 32'd0);
        issue_valid_i = 1'b0;
        issue_rd_en_i = 1'b0;
        cmpl0_valid_i = 1'b1;
        cmpl0_rd_id_i = 5'd3;
        cmpl1_valid_i = 1'b1;
        cmpl1_rd_id_i = 5'd7;
        step();
        idle_inputs();
        check("dual_clr_busy", busy_vec_o,     32'h0);
        check("dual_clr_out",  outstanding_o,  32'd0);
        check("dual_clr_err",  spurious_err_o, 32'd0);

        // Both ports naming the same busy register
        issue_rd(5'd3);
        #1;
        check("same_pre_out", outstanding_o, 32'd1);
        cmpl0_valid_i = 1'b1;
        cmpl0_rd_id_i = 5'd3;
        cmpl1_valid_i = 1'b1;
        cmpl1_rd_id_i = 5'd3;
        step();
        idle_inputs();
        check("same_out",  outstanding_o,  32'd0);
        check("same_busy", busy_vec_o,     32'h0);
        check("same_err",  spurious_err_o, 32'd0);

        // x0 never stalls and never becomes busy
        issue_valid_i  = 1'b1;
        issue_rs1_en_i = 1'b1;
        issue_rs2_en_i = 1'b1;
        issue_rd_en_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x0_ready", issue_ready_o, 32'd1);
            step();
        end
        idle_inputs();
        #1;
        check("x0_busy", busy_vec_o,    32'h0);
        check("x0_out",  outstanding_o, 32'd0);

        // Flush with an issue pending, then a late completion
        issue_rd(5'd1);
        issue_rd(5'd2);
        issue_rd(5'd9);
        #1;
        check("fl_pre_busy", busy_vec_o,    32'h206);
        check("fl_pre_out",  outstanding_o, 32'd3);
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_id_i = 5'd4;
        flush_i       = 1'b1;
        #1;
        check("fl_ready", issue_ready_o, 32'd0);
        step();
        idle_inputs();
        check("fl_busy", busy_vec_o,     32'h0);
        check("fl_out",  outstanding_o,  32'd0);
        check("fl_err",  spurious_err_o, 32'd0);
        cmpl0_valid_i = 1'b1;
        cmpl0_rd_id_i = 5'd2;
        step();
        idle_inputs();
        check("late_err",  spurious_err_o, 32'd1);
        check("late_busy", busy_vec_o,     32'h0);
        check("late_out",  outstanding_o,  32'd0);
        step();
        step();
        check("err_sticky", spurious_err_o, 32'd1);

        // Fill all registers back-to-back, then drain in pairs
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            issue_rd_id_i = 5'(i);
            #1;
            check("fill_ready", issue_ready_o, 32'd1);
            step();
        end
        idle_inputs();
        #1;
        check("fill_out",  outstanding_o, 32'd31);
        check("fill_busy", busy_vec_o,    32'hFFFF_FFFE);
        check("fill_idle", idle_o,        32'd0);
        exp_busy = 32'hFFFF_FFFE;
        for (int i = 1; i <= 31; i += 2) begin
            cmpl0_valid_i = 1'b1;
            cmpl0_rd_id_i = 5'(i);
            exp_busy[i]   = 1'b0;
            if (i < 31) begin
                cmpl1_valid_i = 1'b1;
                cmpl1_rd_id_i = 5'(i + 1);
                exp_busy[i+1] = 1'b0;
            end else begin
                cmpl1_valid_i = 1'b0;
            end
            step();
            check("drain_busy", busy_vec_o, exp_busy);
        end
        idle_inputs();
        #1;
        check("drain_out",  outstanding_o,  32'd0);
        check("drain_idle", idle_o,         32'd1);
        check("drain_err",  spurious_err_o, 32'd1);

        // Reset mid-operation overrides a concurrent issue
        issue_rd(5'd6);
        #1;
        check("mid_pre_busy", busy_vec_o, 32'h40);
        rst           = 1'b1;
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_id_i = 5'd8;
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("mid_rst_busy", busy_vec_o,     32'h0);
        check("mid_rst_out",  outstanding_o,  32'd0);
        check("mid_rst_err",  spurious_err_o, 32'd0);
        check("mid_rst_idle", idle_o,         32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
